mem_store_buffer: RTL and testbench
===================================

# mem_store_buffer

Store-side data-memory path for the MIPS pipeline, in the MEM stage: the write direction that complements the load/writeback path selecting data-memory read data into the register file. It accepts store requests (sb/sh/sw), checks alignment, aligns data into byte lanes with byte enables, buffers them in a small FIFO, and drains them to data memory over a valid/ready handshake. It also flags loads that hit a still-pending store so the hazard unit can stall.

## Interface
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  store request valid (from EX/MEM register)
- st_ready  out  1  buffer can accept a request this cycle
- st_addr  in  32  byte address (ALU result)
- st_data  in  32  store data (rt register value)
- st_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_wvalid  out  1  write request to data memory valid
- mem_wready  in  1  data memory accepts write
- mem_waddr  out  30  word address (byte address [31:2])
- mem_wdata  out  32  lane-aligned write data
- mem_wbe  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- misalign  out  1  one-cycle pulse: a request was rejected
- ld_addr  in  32  byte address of the load currently in MEM
- ld_conflict  out  1  pending store targets the same word as ld_addr
- count  out  log2(DEPTH)+1  occupied entries
- empty  out  1  count == 0

## Operation
- Accept: st_valid && st_ready. st_ready = (count < DEPTH). It is registered-state based and never depends on mem_wready, so there is no same-cycle bypass when full.
- Lane mapping is little-endian; lane = st_addr[1:0].
  - Byte: be = 1 << addr[1:0]; wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - Word: be = 1111; wdata = data.
- Misalignment: half with addr[0]=1, word with addr[1:0]≠00, or size 11.
  - The request is consumed (the handshake completes) but not enqueued.
  - misalign pulses high for exactly one cycle, the cycle after acceptance.
- FIFO stores {waddr, wdata, be} per entry. Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH.
- Drain: mem_wvalid = !empty. The mem_w* outputs present the head entry. The head pops on mem_wvalid && mem_wready.
- While mem_wvalid=1 and mem_wready=0, mem_waddr, mem_wdata and mem_wbe stay stable.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, a pop in cycle N makes st_ready=1 in cycle N+1.
- ld_conflict is combinational. It is 1 if any occupied entry has waddr == ld_addr[31:2], byte enables ignored. An entry popping in the current cycle still counts.
- Stores drain in strict acceptance order. No merging or coalescing.

## Timing
- Reset (rst_n=0, asynchronous):
  - Pointers and count go to 0; mem_wvalid=0, misalign=0, empty=1, st_ready=1.
  - mem_waddr, mem_wdata and mem_wbe go to 0.
  - An entry in flight is discarded; there is no memory write after reset.
- Latency: a store accepted at edge N into an empty buffer gives mem_wvalid=1 after edge N (visible in cycle N+1). With mem_wready held 1 it pops at edge N+1.
- Throughput: 1 store/cycle sustained when mem_wready=1 continuously.
- misalign: high in the cycle after the rejecting edge, low the next, unless another rejection occurs.
- count updates on the accept/pop edge. empty = (count==0). ld_conflict follows FIFO contents the same cycle.

## Test plan
- Reset/idle: assert rst_n=0 mid-operation with 3 entries queued. Required: mem_wvalid=0 and count=0 immediately (asynchronous). After release: st_ready=1, empty=1.
- Lane alignment:
  - sb addr 0x1003, data 0xAABBCCDD → waddr 0x400, be 1000, wdata 0xDDDDDDDD.
  - sh addr 0x1002, data 0x12345678 → be 1100, wdata 0x56785678.
  - sw addr 0x1000 → be 1111, wdata unchanged.
- Misalignment: sh addr 0x1001, then sw addr 0x1002, then size 11. Required for each: misalign pulses one cycle, count stays 0, and no mem_wvalid.
- Full/backpressure: mem_wready=0, push 4 stores. Required: count=4 and st_ready=0; a 5th st_valid is not accepted. mem_w* stay stable for 10 cycles. Then mem_wready=1 → the 4 drain in order, one per cycle.
- Simultaneous push/pop at count=2: required count stays 2 and ordering is preserved. At count=4 with mem_wready=1 and st_valid=1: the push is refused that cycle and accepted the next.
- Load conflict: queue sw to 0x2004. ld_addr 0x2006 → ld_conflict=1; ld_addr 0x2008 → 0. After the entry pops, ld_addr 0x2006 → 0.

Source files
------------

// File: rtl/mem_store_buffer_if.sv
// Store-side bus bundle: store requests coming from EX/MEM and the
// write channel going out to data memory.
// slave  = the store buffer's view (takes requests, drives memory writes).
// master = the surrounding pipeline/memory's view.
interface mem_store_buffer_if;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [1:0]  st_size;
   logic        mem_wvalid;
   logic        mem_wready;
   logic [29:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wbe;

   modport master (
      output st_valid, st_addr, st_data, st_size, mem_wready,
      input  st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wbe
   );

   modport slave (
      input  st_valid, st_addr, st_data, st_size, mem_wready,
      output st_ready, mem_wvalid, mem_waddr, mem_wdata, mem_wbe
   );
endinterface

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: aligns sb/sh/sw into byte lanes, rejects
// misaligned requests, queues stores in order and drains them to data
// memory. Also reports loads that hit a still-pending store word.
module mem_store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mem_store_buffer_if.slave      bus,
   output logic                   misalign,
   input  logic [31:0]            ld_addr,
   output logic                   ld_conflict,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } entry_t;

   entry_t       fifo_q [DEPTH];
   entry_t       fifo_d [DEPTH];
   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic         misalign_q, misalign_d;

   entry_t       new_entry;
   entry_t       head;
   logic         bad_align;
   logic         accept;
   logic         push;
   logic         pop;
   logic [AW:0]  k_v;
   logic [AW-1:0] slot_v;

   // Decode size/address into lane-aligned data, byte enables and alignment fault
   always_comb begin
      new_entry       = '0;
      bad_align       = 1'b0;
      new_entry.waddr = bus.st_addr[31:2];
      case (bus.st_size)
         2'b00: begin
            new_entry.be    = 4'b0001 << bus.st_addr[1:0];
            new_entry.wdata = {4{bus.st_data[7:0]}};
         end
         2'b01: begin
            bad_align       = bus.st_addr[0];
            new_entry.be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
            new_entry.wdata = {2{bus.st_data[15:0]}};
         end
         2'b10: begin
            bad_align       = (bus.st_addr[1:0] != 2'b00);
            new_entry.be    = 4'b1111;
            new_entry.wdata = bus.st_data;
         end
         default: bad_align = 1'b1;
      endcase
   end

   // Occupancy and handshakes; count never exceeds DEPTH (a power of two),
   // so its MSB alone signals "full"
   always_comb begin
      count        = wr_ptr_q - rd_ptr_q;
      empty        = (count == '0);
      bus.st_ready = ~count[AW];
      accept       = bus.st_valid && bus.st_ready;
      push         = accept && !bad_align;
      pop          = !empty && bus.mem_wready;
   end

   // Head presentation; forced to zero while empty so nothing stale leaks out after reset
   always_comb begin
      head           = fifo_q[rd_ptr_q[AW-1:0]];
      bus.mem_wvalid = !empty;
      bus.mem_waddr  = empty ? '0 : head.waddr;
      bus.mem_wdata  = empty ? '0 : head.wdata;
      bus.mem_wbe    = empty ? '0 : head.be;
      misalign       = misalign_q;
   end

   // Next-state: pointer advance, entry write, misalign pulse
   always_comb begin
      wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
      misalign_d = accept && bad_align;
      fifo_d     = fifo_q;
      if (push) fifo_d[wr_ptr_q[AW-1:0]] = new_entry;
   end

   // Word-address match against every occupied entry, head included even if popping now
   always_comb begin
      ld_conflict = 1'b0;
      k_v         = '0;
      slot_v      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         k_v    = (AW+1)'(k);
         slot_v = rd_ptr_q[AW-1:0] + k_v[AW-1:0];
         if ((k_v < count) && (fifo_q[slot_v].waddr == ld_addr[31:2]))
            ld_conflict = 1'b1;
      end
   end

   // Control state with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         misalign_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         misalign_q <= misalign_d;
      end
   end

   // Entry storage; contents only matter while occupied, so no reset
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        misalign, ld_conflict, empty;
   logic [31:0] ld_addr;
   logic [2:0]  count;

   always #5 clk = ~clk;

   mem_store_buffer_if bus ();

   mem_store_buffer #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .misalign    (misalign),
      .ld_addr     (ld_addr),
      .ld_conflict (ld_conflict),
      .count       (count),
      .empty       (empty)
   );

   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } exp_t;

   exp_t q[$];
   bit   mis_pend = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(bit v, logic [31:0] a, logic [31:0] d, logic [1:0] sz,
                        bit wr, logic [31:0] la);
      bus.st_valid   = v;
      bus.st_addr    = a;
      bus.st_data    = d;
      bus.st_size    = sz;
      bus.mem_wready = wr;
      ld_addr        = la;
   endtask

   // Reference: what a store request becomes, from the lane rules
   function automatic void lane(input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] sz, output bit ok, output exp_t e);
      int off = int'(a % 4);
      e.a  = a / 4;
      e.d  = '0;
      e.be = '0;
      ok   = 0;
      if (sz == 0) begin
         ok = 1; e.be = 4'(1 << off); e.d = 32'(d[7:0]) * 32'h01010101;
      end else if (sz == 1) begin
         ok = (a % 2 == 0); e.be = (off >= 2) ? 4'hC : 4'h3; e.d = 32'(d[15:0]) * 32'h00010001;
      end else if (sz == 2) begin
         ok = (off == 0); e.be = 4'hF; e.d = d;
      end
   endfunction

   // One clock: compare every output to the model mid-cycle, then advance the model
   task automatic cycle();
      int   n;
      bit   hit, ok, pop, acc;
      exp_t e;
      @(negedge clk);
      n   = q.size();
      hit = 0;
      foreach (q[i]) if (q[i].a == ld_addr[31:2]) hit = 1;
      chk("st_ready", bus.st_ready, n < DEPTH);
      chk("mem_wvalid", bus.mem_wvalid, n != 0);
      chk("count", count, n);
      chk("empty", empty, n == 0);
      chk("misalign", misalign, mis_pend);
      chk("ld_conflict", ld_conflict, hit);
      chk("mem_waddr", bus.mem_waddr, (n != 0) ? q[0].a : 30'd0);
      chk("mem_wdata", bus.mem_wdata, (n != 0) ? q[0].d : 32'd0);
      chk("mem_wbe", bus.mem_wbe, (n != 0) ? q[0].be : 4'd0);
      pop = (n != 0) && bus.mem_wready;
      acc = bus.st_valid && (n < DEPTH);
      lane(bus.st_addr, bus.st_data, bus.st_size, ok, e);
      @(posedge clk);
      if (pop) begin
         $display("DRAIN  waddr=%08h wdata=%08h be=%04b", q[0].a, q[0].d, q[0].be);
         void'(q.pop_front());
      end
      if (acc) begin
         $display("ACCEPT addr=%08h data=%08h size=%0d %s", bus.st_addr, bus.st_data,
                  bus.st_size, ok ? "queued" : "rejected");
         if (ok) q.push_back(e);
      end
      mis_pend = acc && !ok;
      #1;
   endtask

   task automatic idle(bit wr);
      drive(0, 32'h0, 32'h0, 2'b10, wr, 32'h0);
      cycle();
   endtask

   initial begin
      drive(0, 32'h0, 32'h0, 2'b10, 0, 32'h0);
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset/idle state
      idle(0);
      chk("reset_count", count, 3'd0);

      // Lane alignment
      drive(1, 32'h1003, 32'hAABBCCDD, 2'b00, 0, 32'h0); cycle();
      chk("sb_waddr", bus.mem_waddr, 30'h400);
      chk("sb_be", bus.mem_wbe, 4'b1000);
      chk("sb_wdata", bus.mem_wdata, 32'hDDDDDDDD);
      idle(1);
      drive(1, 32'h1002, 32'h12345678, 2'b01, 0, 32'h0); cycle();
      chk("sh_be", bus.mem_wbe, 4'b1100);
      chk("sh_wdata", bus.mem_wdata, 32'h56785678);
      idle(1);
      drive(1, 32'h1000, 32'hCAFEF00D, 2'b10, 0, 32'h0); cycle();
      chk("sw_be", bus.mem_wbe, 4'b1111);
      chk("sw_wdata", bus.mem_wdata, 32'hCAFEF00D);
      idle(1);

      // Misalignment: three rejected forms
      drive(1, 32'h1001, 32'h1, 2'b01, 1, 32'h0); cycle();
      chk("mis_sh_pulse", misalign, 1'b1);
      chk("mis_sh_count", count, 3'd0);
      idle(1);
      chk("mis_sh_low", misalign, 1'b0);
      drive(1, 32'h1002, 32'h2, 2'b10, 1, 32'h0); cycle();
      chk("mis_sw_pulse", misalign, 1'b1);
      chk("mis_sw_wvalid", bus.mem_wvalid, 1'b0);
      idle(1);
      drive(1, 32'h1000, 32'h3, 2'b11, 1, 32'h0); cycle();
      chk("mis_rsv_pulse", misalign, 1'b1);
      idle(1);

      // Full/backpressure
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h3000 + 32'(4 * i), 32'h100 + 32'(i), 2'b10, 0, 32'h0);
         cycle();
      end
      chk("full_count", count, 3'd4);
      chk("full_ready", bus.st_ready, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive(1, 32'h4000, 32'hDEAD, 2'b10, 0, 32'h0);
         cycle();
         chk("stable_waddr", bus.mem_waddr, 30'(32'h3000 >> 2));
      end
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", bus.mem_wdata, 32'h100 + 32'(i));
         idle(1);
      end
      chk("drained", count, 3'd0);

      // Simultaneous push/pop at count=2
      drive(1, 32'h5000, 32'hA0, 2'b10, 0, 32'h0); cycle();
      drive(1, 32'h5004, 32'hA1, 2'b10, 0, 32'h0); cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h5008 + 32'(4 * i), 32'hA2 + 32'(i), 2'b10, 1, 32'h0);
         cycle();
         chk("pushpop_count", count, 3'd2);
      end
      idle(1); idle(1);

      // Full with mem_wready=1 and st_valid=1: refused, then accepted
      for (int i = 0; i < 4; i++) begin
         drive(1, 32'h6000 + 32'(4 * i), 32'hB0 + 32'(i), 2'b10, 0, 32'h0);
         cycle();
      end
      drive(1, 32'h6010, 32'hB4, 2'b10, 1, 32'h0); cycle();
      chk("full_pop_count", count, 3'd3);
      chk("full_pop_ready", bus.st_ready, 1'b1);
      cycle();
      chk("next_push_count", count, 3'd3);
      for (int i = 0; i < 4; i++) idle(1);

      // Load conflict
      drive(1, 32'h2004, 32'h77, 2'b10, 0, 32'h0); cycle();
      ld_addr = 32'h2006; #1;
      chk("ldc_hit", ld_conflict, 1'b1);
      ld_addr = 32'h2008; #1;
      chk("ldc_miss", ld_conflict, 1'b0);
      drive(0, 32'h0, 32'h0, 2'b10, 1, 32'h2006); cycle();
      chk("ldc_after_pop", ld_conflict, 1'b0);

      // Asynchronous reset with 3 entries queued
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h7000 + 32'(4 * i), 32'hC0 + 32'(i), 2'b10, 0, 32'h0);
         cycle();
      end
      drive(0, 32'h0, 32'h0, 2'b10, 0, 32'h0);
      rst_n = 1'b0; #1;
      chk("rst_wvalid", bus.mem_wvalid, 1'b0);
      chk("rst_count", count, 3'd0);
      q.delete();
      mis_pend = 0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      idle(1);
      chk("rst_ready", bus.st_ready, 1'b1);
      chk("rst_empty", empty, 1'b1);

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         logic [1:0] sz;
         sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         drive(bit'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 63)), $urandom,
               sz, bit'($urandom_range(0, 2) != 0), 32'h1000 + 32'($urandom_range(0, 63)));
         cycle();
      end
      for (int i = 0; i < 6; i++) idle(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
